// File: rtl/parcv1_dmem_bridge.sv
// ---------------------------------------------------------------------------
// parcv1_dmem_bridge
//
// Bridges the PARCv1 core's single-outstanding data-memory request onto a
// simple request/grant/rvalid word bus. It handles byte-lane steering for
// stores, load extraction with sign/zero extension, misalignment and illegal
// size-code detection, and a per-access timeout. All outputs are registered.
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rst          synchronous reset, active low (0 = reset)
//   core_req     access request from the core, only looked at while idle
//   core_we      1 = store, 0 = load
//   core_addr    byte address
//   core_wdata   store data, LSB-justified
//   core_funct3  RV32I size code (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   core_rdata   extended load data, valid while core_resp is high
//   core_resp    one-cycle completion pulse
//   core_err     error flag, valid while core_resp is high
//   core_busy    high whenever an access is in flight (not idle)
//   bus_req      bus request, held until bus_gnt
//   bus_we       bus write enable, stable while bus_req is high
//   bus_addr     word-aligned bus address, stable while bus_req is high
//   bus_be       byte enables, stable while bus_req is high
//   bus_wdata    lane-replicated store data, stable while bus_req is high
//   bus_gnt      bus grant, only looked at while requesting
//   bus_rvalid   bus response valid, only looked at while waiting
//   bus_rdata    bus read data, captured with bus_rvalid
// ---------------------------------------------------------------------------
module parcv1_dmem_bridge #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [XLEN-1:0] core_addr,
    input  logic [XLEN-1:0] core_wdata,
    input  logic [2:0]      core_funct3,
    output logic [XLEN-1:0] core_rdata,
    output logic            core_resp,
    output logic            core_err,
    output logic            core_busy,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata
);

    // The counter must be able to hold TIMEOUT_CYC: a grant on the very last
    // request cycle moves into WAIT one count past the limit.
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        addrLo_q;
    logic [2:0]        funct3_q;
    logic              we_q;

    logic              busReq_q;
    logic              busWe_q;
    logic [XLEN-1:0]   busAddr_q;
    logic [3:0]        busBe_q;
    logic [XLEN-1:0]   busWdata_q;
    logic              resp_q;
    logic              err_q;
    logic              busy_q;
    logic [XLEN-1:0]   rdata_q;

    logic              legal_d;
    logic [3:0]        be_d;
    logic [XLEN-1:0]   wdata_d;
    logic [XLEN-1:0]   loadData_d;
    logic [7:0]        byteSel;
    logic [15:0]       halfSel;
    logic              timeoutHit;

    // Legality of the access presented by the core. Stores only exist for
    // b/h/w; unsigned codes are load-only. Halves need addr[0]=0, words need
    // addr[1:0]=00.
    always_comb begin
        legal_d = 1'b0;
        case (core_funct3)
            3'b000:  legal_d = 1'b1;
            3'b001:  legal_d = ~core_addr[0];
            3'b010:  legal_d = (core_addr[1:0] == 2'b00);
            3'b100:  legal_d = ~core_we;
            3'b101:  legal_d = ~core_we & ~core_addr[0];
            default: legal_d = 1'b0;
        endcase
    end

    // Store lane steering: narrow data is replicated across the word so the
    // byte enables alone select the target lanes. Loads read the full word.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = core_wdata;
        if (core_we) begin
            case (core_funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << core_addr[1:0];
                    wdata_d = {(XLEN/8){core_wdata[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << {core_addr[1], 1'b0};
                    wdata_d = {(XLEN/16){core_wdata[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = core_wdata;
                end
            endcase
        end
    end

    // Load extraction from the returning bus word, using the low address
    // bits and size code captured when the access was accepted.
    always_comb begin
        byteSel    = bus_rdata[{addrLo_q, 3'b000} +: 8];
        halfSel    = bus_rdata[{addrLo_q[1], 4'b0000} +: 16];
        loadData_d = bus_rdata;
        case (funct3_q)
            3'b000:  loadData_d = {{(XLEN-8){byteSel[7]}}, byteSel};
            3'b100:  loadData_d = {{(XLEN-8){1'b0}}, byteSel};
            3'b001:  loadData_d = {{(XLEN-16){halfSel[15]}}, halfSel};
            3'b101:  loadData_d = {{(XLEN-16){1'b0}}, halfSel};
            default: loadData_d = bus_rdata;
        endcase
    end

    // Counter reaches its last allowed value; once there, any cycle without
    // progress ends the access with an error.
    always_comb begin
        timeoutHit = (cnt_q >= CNT_LAST);
    end

    // Main access FSM. Every output is a register updated here so the core
    // and bus see glitch-free signals. core_resp is a single-cycle pulse set
    // on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addrLo_q   <= 2'b00;
            funct3_q   <= 3'b000;
            we_q       <= 1'b0;
            busReq_q   <= 1'b0;
            busWe_q    <= 1'b0;
            busAddr_q  <= '0;
            busBe_q    <= 4'b0000;
            busWdata_q <= '0;
            resp_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            resp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (core_req) begin
                        addrLo_q   <= core_addr[1:0];
                        funct3_q   <= core_funct3;
                        we_q       <= core_we;
                        busWe_q    <= core_we;
                        busAddr_q  <= {core_addr[XLEN-1:2], 2'b00};
                        busBe_q    <= be_d;
                        busWdata_q <= wdata_d;
                        busy_q     <= 1'b1;
                        if (legal_d) begin
                            state_q  <= REQ;
                            busReq_q <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            // Illegal accesses never touch the bus.
                            state_q <= RESP;
                            resp_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end

                REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A simultaneous rvalid is deliberately ignored here; the
                    // data phase only starts in WAIT.
                    if (bus_gnt) begin
                        state_q  <= WAIT;
                        busReq_q <= 1'b0;
                    end else if (timeoutHit) begin
                        state_q  <= RESP;
                        busReq_q <= 1'b0;
                        resp_q   <= 1'b1;
                        err_q    <= 1'b1;
                        rdata_q  <= '0;
                    end
                end

                WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // rvalid takes priority over a timeout in the same cycle.
                    if (bus_rvalid) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= we_q ? '0 : loadData_d;
                    end else if (timeoutHit) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end

                RESP: begin
                    // A request held by the core during this cycle is picked
                    // up next cycle in IDLE.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                end

                default: begin
                    state_q  <= IDLE;
                    busReq_q <= 1'b0;
                    busy_q   <= 1'b0;
                    err_q    <= 1'b0;
                end
            endcase
        end
    end

    assign core_rdata = rdata_q;
    assign core_resp  = resp_q;
    assign core_err   = err_q;
    assign core_busy  = busy_q;
    assign bus_req    = busReq_q;
    assign bus_we     = busWe_q;
    assign bus_addr   = busAddr_q;
    assign bus_be     = busBe_q;
    assign bus_wdata  = busWdata_q;

endmodule
